d5m_bin2x2_stream: RTL

//  Downstream stage of the D5M capture controller. Consumes its 8-bit raw Bayer pixel stream and emits one

---
 rtl/d5m_bin2x2_stream_pkg.sv | 7 +
 rtl/d5m_bin2x2_stream_if.sv | 10 +
 rtl/d5m_bin2x2_stream_fifo.sv | 38 +++
 rtl/d5m_bin2x2_stream.sv | 83 ++++++++
 4 files changed

// File: rtl/d5m_bin2x2_stream_pkg.sv
// d5m_bin2x2_stream_pkg: shared sensor geometry, pixel width and FSM encoding
package d5m_bin2x2_stream_pkg;
  localparam int D5M_COLS  = 2592;
  localparam int D5M_LINES = 1944;
  localparam int D5M_DW    = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACTIVE} state_t;
endpackage

// File: rtl/d5m_bin2x2_stream_if.sv
// d5m_bin2x2_stream_if: pixel stream bundle with valid/ready, sop/eop framing
interface d5m_bin2x2_stream_if #(parameter int DW = 8);
  logic          valid;
  logic          ready;
  logic          sop;
  logic          eop;
  logic [DW-1:0] data;
  modport master(output valid, data, sop, eop, input ready);
  modport slave(input valid, data, sop, eop, output ready);
endinterface

// File: rtl/d5m_bin2x2_stream_fifo.sv
// d5m_bin2x2_stream_fifo: first-word-fall-through FIFO with full/empty flags
module d5m_bin2x2_stream_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         do_wr, do_rd;
  always_comb begin
    empty   = wp_q == rp_q;
    full    = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    do_rd   = rd_en && !empty;
    do_wr   = wr_en && (!full || do_rd);
    wp_d    = wp_q + (AW+1)'(do_wr);
    rp_d    = rp_q + (AW+1)'(do_rd);
    rd_data = mem[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wp_q[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
endmodule

// File: rtl/d5m_bin2x2_stream.sv
// d5m_bin2x2_stream: 2x2 Bayer-quad mean binning of a raw sensor stream into a backpressured FIFO output
module d5m_bin2x2_stream
  import d5m_bin2x2_stream_pkg::*;
#(
  parameter int COLS       = D5M_COLS,
  parameter int LINES      = D5M_LINES,
  parameter int DW         = D5M_DW,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  d5m_bin2x2_stream_if.slave         in_s,
  d5m_bin2x2_stream_if.master        out_m,
  input  logic                       clr_status,
  output logic                       overflow,
  output logic                       frame_err
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(LINES);
  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d, c;
  logic [RW-1:0] row_q, row_d, r;
  logic [DW-1:0] h_q, h_d;
  logic [DW:0]   lb [COLS/2];
  logic [DW:0]   rd_q, pair;
  logic [DW+1:0] quad, pdat_q, pdat_d, fifo_q;
  logic          push_q, push_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic          restart, beat, last, wr_en, rd_en, err, full, empty;
  always_comb begin
    restart = in_s.sop || state_q == ST_ARMED;
    c       = restart ? '0 : col_q;
    r       = restart ? '0 : row_q;
    beat    = in_s.valid && (restart || state_q == ST_ACTIVE);
    last    = r == RW'(LINES-1) && c == CW'(COLS-1);
    pair    = {1'b0, h_q} + {1'b0, in_s.data};
    quad    = {1'b0, rd_q} + {1'b0, pair};
    wr_en   = beat && !r[0] && c[0];
    rd_en   = beat && r[0] && !c[0];
    state_d = beat ? (last ? ST_IDLE : ST_ACTIVE) : (in_s.sop ? ST_ARMED : state_q);
    col_d   = beat ? (c == CW'(COLS-1) ? '0 : c + CW'(1)) : c;
    row_d   = beat && c == CW'(COLS-1) ? (last ? '0 : r + RW'(1)) : r;
    h_d     = beat && !c[0] ? in_s.data : h_q;
    push_d  = beat && r[0] && c[0];
    pdat_d  = {r == RW'(1) && c == CW'(1), last, quad[DW+1:2]};
    err     = (in_s.sop && state_q == ST_ACTIVE) || (beat && in_s.eop && !last) ||
              (in_s.valid && state_q == ST_IDLE && !in_s.sop);
    ferr_d  = err ? 1'b1 : clr_status ? 1'b0 : ferr_q;
    ovf_d   = push_q && full && !out_m.ready ? 1'b1 : clr_status ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (wr_en) lb[c[CW-1:1]] <= pair;
    if (rd_en) rd_q <= lb[c[CW-1:1]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      push_q  <= 1'b0;
      pdat_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      push_q  <= push_d;
      pdat_q  <= pdat_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  d5m_bin2x2_stream_fifo #(.W(DW+2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(push_q), .wr_data(pdat_q),
    .rd_en(out_m.ready), .rd_data(fifo_q), .full(full), .empty(empty)
  );
  assign in_s.ready  = 1'b1;
  assign out_m.valid = !empty;
  assign {out_m.sop, out_m.eop, out_m.data} = empty ? '0 : fifo_q;
  assign overflow    = ovf_q;
  assign frame_err   = ferr_q;
endmodule
